// File: rtl/corr_pkg.sv
// Shared types and width helpers for the cross-correlation sequencer.
package corr_pkg;

    // Default maximum number of samples per input vector
    localparam int CORR_LEN = 2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } corr_seq_state_t;

    // Sample address width for a given maximum vector length
    function automatic int addr_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Result address width: lags 0 .. 2*len-2
    function automatic int res_w(input int len);
        return (len > 1) ? $clog2(2 * len - 1) : 1;
    endfunction

    localparam int CORR_AW = addr_w(CORR_LEN);
    localparam int CORR_RW = res_w(CORR_LEN);

endpackage

// File: rtl/correlate_seq_if.sv
// Handshake and memory/MAC bus of the correlation sequencer.
// Optional abort port pair present when CORR_SEQ_ABORT_EN is defined.
interface correlate_seq_if import corr_pkg::*; #(
    parameter int LEN = CORR_LEN
);
    localparam int AW = addr_w(LEN);
    localparam int RW = res_w(LEN);

    logic          start;
    logic [AW:0]   len;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          rd_en;
    logic          mac_en;
    logic          mac_clr;
    logic [RW-1:0] res_addr;
    logic          res_we;
    logic          busy;
    logic          done;
`ifdef CORR_SEQ_ABORT_EN
    logic          abort;
    logic          aborted;

    modport master (
        output start, len, abort,
        input  a_addr, b_addr, rd_en, mac_en, mac_clr, res_addr, res_we, busy, done, aborted
    );

    modport slave (
        input  start, len, abort,
        output a_addr, b_addr, rd_en, mac_en, mac_clr, res_addr, res_we, busy, done, aborted
    );
`else
    modport master (
        output start, len,
        input  a_addr, b_addr, rd_en, mac_en, mac_clr, res_addr, res_we, busy, done
    );

    modport slave (
        input  start, len,
        output a_addr, b_addr, rd_en, mac_en, mac_clr, res_addr, res_we, busy, done
    );
`endif

endinterface

// File: rtl/corr_index_gen.sv
// Lag/term counters for the correlation walk. For lag n the term index i
// runs from max(0, n-(L-1)) to min(n, L-1); a = i, b = i + (L-1-n).
// Addresses are registered and hold when not stepping.
module corr_index_gen #(
    parameter int AW = 11,
    parameter int RW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] lm1,
    input  logic          step,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [RW-1:0] n,
    output logic          first,
    output logic          last,
    output logic          lag_end
);

    logic [RW-1:0] n_q;
    logic [AW-1:0] i_q;
    logic [AW-1:0] b_q;
    logic [AW-1:0] lm1_q;

    logic [RW-1:0] lm1_w;
    logic [RW-1:0] i_w;
    logic [RW-1:0] lo;
    logic [RW-1:0] hi;
    logic [RW-1:0] n_nx;
    logic [RW-1:0] lo_nx;
    logic [RW-1:0] b_nx;

    // Lag bounds; n is compared with L-1 before any subtraction
    always_comb begin
        lm1_w = RW'(lm1_q);
        i_w   = RW'(i_q);
        lo    = (n_q > lm1_w) ? (n_q - lm1_w) : '0;
        hi    = (n_q < lm1_w) ? n_q : lm1_w;
        n_nx  = n_q + 1'b1;
        lo_nx = (n_nx > lm1_w) ? (n_nx - lm1_w) : '0;
        b_nx  = (n_nx > lm1_w) ? '0 : (lm1_w - n_nx);
    end

    assign first   = (i_w == lo);
    assign lag_end = (i_w == hi);
    assign last    = lag_end && (n_q == (lm1_w << 1));

    assign a_addr = i_q;
    assign b_addr = b_q;
    assign n      = n_q;

    // Counter update: restart at lag 0 on load, advance one term per step
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= '0;
            i_q   <= '0;
            b_q   <= '0;
            lm1_q <= '0;
        end else if (load) begin
            n_q   <= '0;
            i_q   <= '0;
            b_q   <= lm1;
            lm1_q <= lm1;
        end else if (step) begin
            if (lag_end) begin
                n_q <= n_nx;
                i_q <= AW'(lo_nx);
                b_q <= AW'(b_nx);
            end else begin
                i_q <= i_q + 1'b1;
                b_q <= b_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/correlate_seq.sv
// Cross-correlation control sequencer: FSM plus the strobe delay pipeline
// feeding the MAC and result RAM. Optional abort support is compiled in
// when CORR_SEQ_ABORT_EN is defined.
module correlate_seq import corr_pkg::*; #(
    parameter int LEN = CORR_LEN
) (
    input  logic              clk,
    input  logic              reset,
    correlate_seq_if.slave    bus
);

    localparam int AW = addr_w(LEN);
    localparam int RW = res_w(LEN);
    localparam logic [AW:0] LEN_V = (AW + 1)'(LEN);

    corr_seq_state_t state;
    corr_seq_state_t state_nxt;

    logic          flush_cnt;
    logic          load;
    logic          rd;
    logic          busy_c;
    logic          done_c;
    logic          abort_hit;
    logic          step;
    logic [AW:0]   len_sat;
    logic [AW-1:0] lm1_in;

    logic          first;
    logic          last;
    logic          lag_end;
    logic [RW-1:0] n_cur;

    logic          mac_en_p1;
    logic          mac_clr_p1;
    logic          lag_end_p1;
    logic [RW-1:0] n_p1;
    logic          res_we_p2;
    logic [RW-1:0] res_addr_p2;

    assign len_sat = (bus.len > LEN_V) ? LEN_V : bus.len;
    assign lm1_in  = AW'(len_sat - (AW + 1)'(1));
    // Hold the final term's addresses once the walk is complete
    assign step    = rd && !last;

    corr_index_gen #(
        .AW (AW),
        .RW (RW)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .lm1     (lm1_in),
        .step    (step),
        .a_addr  (bus.a_addr),
        .b_addr  (bus.b_addr),
        .n       (n_cur),
        .first   (first),
        .last    (last),
        .lag_end (lag_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Second FLUSH cycle marker; cleared whenever FLUSH is not continuing
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= 1'b0;
        end else begin
            flush_cnt <= (state == FLUSH) && (state_nxt == FLUSH);
        end
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rd        = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        abort_hit = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end
                end
            end
            RUN: begin
                rd     = 1'b1;
                busy_c = 1'b1;
                if (last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                busy_c = 1'b1;
                if (flush_cnt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef CORR_SEQ_ABORT_EN
        if (bus.abort && ((state == RUN) || (state == FLUSH))) begin
            abort_hit = 1'b1;
            state_nxt = IDLE;
        end
`endif
    end

    assign bus.rd_en = rd;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;

    // ---- stage p1: term issued last cycle reaches the MAC ----
    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            mac_en_p1  <= 1'b0;
            mac_clr_p1 <= 1'b0;
            lag_end_p1 <= 1'b0;
        end else begin
            mac_en_p1  <= rd;
            mac_clr_p1 <= rd && first;
            lag_end_p1 <= rd && lag_end;
        end
    end

    // Lag index travelling with the p1 strobes
    always_ff @(posedge clk) begin
        if (rd) begin
            n_p1 <= n_cur;
        end
    end

    // ---- stage p2: accumulator holds the completed lag, write it out ----
    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            res_we_p2 <= 1'b0;
        end else begin
            res_we_p2 <= mac_en_p1 && lag_end_p1;
        end
    end

    // Result address held from the write strobe onward
    always_ff @(posedge clk) begin
        if (reset) begin
            res_addr_p2 <= '0;
        end else if (mac_en_p1 && lag_end_p1) begin
            res_addr_p2 <= n_p1;
        end
    end

    assign bus.mac_en   = mac_en_p1;
    assign bus.mac_clr  = mac_clr_p1;
    assign bus.res_we   = res_we_p2;
    assign bus.res_addr = res_addr_p2;

`ifdef CORR_SEQ_ABORT_EN
    logic aborted_q;

    // One-cycle abort acknowledge; reset takes precedence
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_hit;
        end
    end

    assign bus.aborted = aborted_q;
`endif

endmodule

// File: tb/tb_correlate_seq.sv
// Testbench for correlate_seq with a lag/term enumeration reference model.
// Abort scenario compiled in when CORR_SEQ_ABORT_EN is defined.
module tb_correlate_seq;
    import corr_pkg::*;

    localparam int LEN  = 8;
    localparam int AW   = addr_w(LEN);
    localparam int RW   = res_w(LEN);
    localparam int MAXC = LEN * LEN + 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    correlate_seq_if #(.LEN(LEN)) bus ();

    correlate_seq #(.LEN(LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int e_rd   [0:MAXC];
    int e_men  [0:MAXC];
    int e_clr  [0:MAXC];
    int e_we   [0:MAXC];
    int e_ra   [0:MAXC];
    int e_busy [0:MAXC];
    int e_done [0:MAXC];
    int e_achk [0:MAXC];
    int e_a    [0:MAXC];
    int e_b    [0:MAXC];
    int ncyc;
    int we_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected per-cycle behaviour of a run of length L; cycle 1 follows the start edge
    function automatic void build_model(input int L);
        int c;
        int lo;
        int hi;
        for (int k = 0; k <= MAXC; k++) begin
            e_rd[k] = 0; e_men[k] = 0; e_clr[k] = 0; e_we[k] = 0; e_ra[k] = 0;
            e_busy[k] = 0; e_done[k] = 0; e_achk[k] = 0; e_a[k] = 0; e_b[k] = 0;
        end
        if (L == 0) begin
            e_done[1] = 1;
            ncyc = 2;
            return;
        end
        c = 1;
        for (int n = 0; n <= 2 * L - 2; n++) begin
            lo = (n > L - 1) ? n - (L - 1) : 0;
            hi = (n < L - 1) ? n : L - 1;
            for (int i = lo; i <= hi; i++) begin
                e_rd[c] = 1;
                e_achk[c] = 1;
                e_a[c] = i;
                e_b[c] = i + (L - 1 - n);
                e_men[c + 1] = 1;
                if (i == lo) e_clr[c + 1] = 1;
                if (i == hi) begin
                    e_we[c + 2] = 1;
                    e_ra[c + 2] = n;
                end
                c++;
            end
        end
        for (int k = 1; k <= L * L + 2; k++) e_busy[k] = 1;
        e_done[L * L + 3] = 1;
        for (int k = L * L + 1; k <= L * L + 4; k++) begin
            e_achk[k] = 1;
            e_a[k] = L - 1;
            e_b[k] = 0;
        end
        ncyc = L * L + 4;
    endfunction

    task automatic run_seq(input int len_in, input int L, input bit noise);
        int we_cnt;
        build_model(L);
        we_cnt = 0;
        we_cyc.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = (AW + 1)'(len_in);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            check("rd_en",   32'(bus.rd_en),   32'(e_rd[c]));
            check("mac_en",  32'(bus.mac_en),  32'(e_men[c]));
            check("mac_clr", 32'(bus.mac_clr), 32'(e_clr[c]));
            check("res_we",  32'(bus.res_we),  32'(e_we[c]));
            check("busy",    32'(bus.busy),    32'(e_busy[c]));
            check("done",    32'(bus.done),    32'(e_done[c]));
            if (e_achk[c] != 0) begin
                check("a_addr", 32'(bus.a_addr), 32'(e_a[c]));
                check("b_addr", 32'(bus.b_addr), 32'(e_b[c]));
            end
            if (e_we[c] != 0) check("res_addr", 32'(bus.res_addr), 32'(e_ra[c]));
            if (bus.res_we === 1'b1) begin
                we_cnt++;
                we_cyc.push_back(c);
            end
            // Spurious starts while the run is not idle must be ignored
            bus.start = noise && (c < ncyc) && ($urandom_range(0, 3) == 0);
        end
        bus.start = 1'b0;
        check("we_count", 32'(we_cnt), 32'((L == 0) ? 0 : 2 * L - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},    32'(bus.rd_en),    32'd0);
        check({tag, "_mac_en"},   32'(bus.mac_en),   32'd0);
        check({tag, "_mac_clr"},  32'(bus.mac_clr),  32'd0);
        check({tag, "_res_we"},   32'(bus.res_we),   32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_a_addr"},   32'(bus.a_addr),   32'd0);
        check({tag, "_b_addr"},   32'(bus.b_addr),   32'd0);
        check({tag, "_res_addr"}, 32'(bus.res_addr), 32'd0);
    endtask

    int we_ref[5] = '{3, 5, 8, 10, 11};
    int rl;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.len   = '0;
`ifdef CORR_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
`ifdef CORR_SEQ_ABORT_EN
        check("reset_aborted", 32'(bus.aborted), 32'd0);
`endif
        reset = 1'b0;

        // L=3 with the documented write cycles
        run_seq(3, 3, 1'b0);
        check("l3_we_n", 32'(we_cyc.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < we_cyc.size()) check("l3_we_cycle", 32'(we_cyc[k]), 32'(we_ref[k]));
        end

        // L=1
        run_seq(1, 1, 1'b0);
        if (we_cyc.size() > 0) check("l1_we_cycle", 32'(we_cyc[0]), 32'd3);

        // Zero length and oversize length
        run_seq(0, 0, 1'b1);
        run_seq(LEN + 5, LEN, 1'b0);

        // Random lengths with spurious starts
        for (int r = 0; r < 6; r++) begin
            rl = $urandom_range(1, LEN);
            run_seq(rl, rl, 1'b1);
        end

        // Reset during cycle 4 of an L=3 run
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = (AW + 1)'(3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postreset_done",  32'(bus.done),  32'd0);
            check("postreset_rd_en", 32'(bus.rd_en), 32'd0);
        end
        run_seq(3, 3, 1'b0);

`ifdef CORR_SEQ_ABORT_EN
        // Abort in IDLE is ignored
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort", 32'(bus.aborted), 32'd0);

        // Abort during cycle 6 of an L=3 run
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = (AW + 1)'(3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("aborted_pulse", 32'(bus.aborted), 32'd1);
        check("abort_mac_en",  32'(bus.mac_en),  32'd0);
        check("abort_res_we",  32'(bus.res_we),  32'd0);
        for (int c = 8; c <= 16; c++) begin
            @(negedge clk);
            check("abort_aborted", 32'(bus.aborted), 32'd0);
            check("abort_we",      32'(bus.res_we),  32'd0);
            check("abort_done",    32'(bus.done),    32'd0);
            check("abort_busy",    32'(bus.busy),    32'd0);
        end
        run_seq(2, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/correlate_seq.md
# correlate_seq

Control sequencer for the cross-correlation MAC datapath. On `start` it walks every output lag `n = 0 … 2L-2` and every valid term of that lag. Per term it issues read addresses to the A and B sample memories, clear/accumulate strobes to the external MAC, and a result write strobe when each lag completes. It sits between the top-level mode FSM, which uses the `start`/`done` handshake, and the sample RAMs, multiplier-accumulator and result RAM.

## Interface
- `LEN`, 2000: maximum samples per input vector.
- `AW`, `$clog2(LEN)`: sample address width.
- `RW`, `$clog2(2*LEN-1)`: result address width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a run; sampled only in IDLE.
- `len` input AW+1: vector length L for this run; latched on accepted `start`.
- `a_addr` output AW: A-memory read address.
- `b_addr` output AW: B-memory read address.
- `rd_en` output 1: memory read strobe; both memories have 1-cycle synchronous read.
- `mac_en` output 1: MAC updates its accumulator this edge.
- `mac_clr` output 1: with `mac_en`, the accumulator loads the product instead of adding it.
- `res_addr` output RW: result index `n`.
- `res_we` output 1: write accumulator to `res_addr`.
- `busy` output 1: high in RUN and FLUSH.
- `done` output 1: one-cycle pulse at end of run.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE→RUN on `start`.
  - RUN→FLUSH after the last term is issued.
  - FLUSH→DONE after 2 cycles.
  - DONE→IDLE unconditionally.
- Length handling on accepted `start`:
  - `len=0`: IDLE→DONE directly, no strobes.
  - `len>LEN`: saturate to LEN.
- Term enumeration: for each `n` ascending, `i` runs from `max(0, n-(L-1))` to `min(n, L-1)` ascending.
  - `a_addr = i`
  - `b_addr = i + (L-1-n)`
  - This yields L² terms total.
- Strobes per term:
  - In RUN, `rd_en=1` every cycle; one term per cycle, no bubbles between lags.
  - `mac_en` is `rd_en` delayed 1 cycle.
  - `mac_clr` is high with the `mac_en` of each lag's first term.
  - `res_we` pulses 1 cycle after each lag's last `mac_en`, with `res_addr=n` held for that cycle.
- Index arithmetic is unsigned. Lower-bound terms are computed without underflow: compare `n` with `L-1` before subtracting.
- `start` in any state except IDLE is ignored.
- Reset mid-run:
  - Next state is IDLE.
  - All strobes are 0 from the reset edge on.
  - No `done` is issued.
  - The partial result RAM contents are undefined.

## Timing
- Reset values: all outputs 0, state IDLE.
- Addresses hold their last value when `rd_en=0`.
- `start` is sampled at edge E0.
  - `rd_en` is high in cycles 1…L².
  - FLUSH occupies cycles L²+1 and L²+2.
  - `done` is high in cycle L²+3.
- Start-to-`done` latency is L²+3 cycles; `busy` is high in cycles 1…L²+2.
- Last `res_we` (n=2L-2) is in cycle L²+2.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `CORR_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit).
  - `abort` high in RUN or FLUSH: next state is IDLE, all pending `mac_en`/`res_we` are suppressed, `aborted` pulses 1 cycle, and `done` is not asserted.
  - `abort` in IDLE or DONE is ignored.
  - `abort` and `reset` together: reset wins, and `aborted` stays 0.
- Undefined: neither port exists; a run always completes.

## Structure
- Package `corr_pkg`:
  - state enum `corr_seq_state_t` (IDLE, RUN, FLUSH, DONE);
  - default `LEN` constant;
  - width helper constants.
- Sub-module `corr_index_gen`:
  - holds the `n`/`i` counters and the lag-bound computation;
  - outputs `a_addr`, `b_addr`, `first`, `last` and `lag_end`.
- The top module holds the FSM and the strobe delay pipeline.

## Test plan
- L=3: term sequence (a,b) = (0,2) (0,1) (1,2) (0,0) (1,1) (2,2) (1,0) (2,1) (2,0).
  - `mac_clr` on terms 1, 2, 4, 7, 9.
  - `res_we` for n=0…4 in cycles 3, 5, 8, 10, 11.
  - `done` in cycle 12.
- L=1: one term (0,0) in cycle 1, `res_we n=0` in cycle 3, `done` in cycle 4.
- `len=0` → `done` 1 cycle after `start`, no `rd_en`/`res_we`. `len=LEN+5` → a full LEN run.
- `start` pulsed during RUN and during DONE → ignored; total `res_we` count equals 2L-1.
- `reset` asserted in cycle 4 of an L=3 run → all outputs 0 in cycle 5; a fresh `start` then gives the full L=3 sequence.
- With `CORR_SEQ_ABORT_EN`, `abort` in cycle 6 of an L=3 run → `aborted` pulses in cycle 7, no further `res_we`, no `done`.
